// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin sharing of one memory RW port among several requesters
module memory_port_arbiter #(
    parameter int REQUESTERS   = 4,
    parameter int DATAW        = 32,
    parameter int WORDW        = 1024,
    parameter int ADDRW        = $clog2(WORDW),
    parameter int READ_LATENCY = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [REQUESTERS-1:0]         i_req_valid,
    output logic [REQUESTERS-1:0]         o_req_ready,
    input  logic [REQUESTERS-1:0]         i_req_write,
    input  logic [REQUESTERS*ADDRW-1:0]   i_req_address,
    input  logic [REQUESTERS*DATAW-1:0]   i_req_data,
    input  logic [REQUESTERS*DATAW-1:0]   i_req_mask,
    output logic [REQUESTERS-1:0]         o_rsp_valid,
    output logic [DATAW-1:0]              o_rsp_data,
    output logic                          o_me,
    output logic                          o_we,
    output logic [ADDRW-1:0]              o_adr,
    output logic [DATAW-1:0]              o_d,
    output logic [DATAW-1:0]              o_wem,
    input  logic [DATAW-1:0]              i_q
);
    localparam int IW = $clog2(REQUESTERS);
    localparam int RL = READ_LATENCY;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant;
    logic          grant_any;
    logic          hs;
    logic [RL:0]   tag_v;
    logic [IW-1:0] tag_id [RL+1];

    // search downward from the farthest candidate so the nearest valid one after last_grant wins
    always_comb begin
        grant     = last_grant;
        grant_any = 1'b0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            if (i_req_valid[(int'(last_grant) + i) % REQUESTERS]) begin
                grant     = IW'((int'(last_grant) + i) % REQUESTERS);
                grant_any = 1'b1;
            end
        end
    end

    assign hs          = grant_any && i_rst_n;
    assign o_req_ready = hs ? {{(REQUESTERS-1){1'b0}}, 1'b1} << grant : '0;

    // register the granted request onto the memory port; fields hold when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_me       <= 1'b0;
            o_we       <= 1'b0;
            o_adr      <= '0;
            o_d        <= '0;
            o_wem      <= '0;
            last_grant <= IW'(REQUESTERS - 1);
        end else begin
            o_me <= hs;
            o_we <= hs && i_req_write[grant];
            if (hs) begin
                last_grant <= grant;
                o_adr      <= i_req_address[grant*ADDRW +: ADDRW];
                o_d        <= i_req_data[grant*DATAW +: DATAW];
                o_wem      <= i_req_mask[grant*DATAW +: DATAW];
            end
        end
    end

    // tag pipeline: stage 0 lines up with o_me, stage RL with valid memory read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_v <= '0;
            for (int i = 0; i <= RL; i++) tag_id[i] <= '0;
        end else begin
            tag_v     <= {tag_v[RL-1:0], hs && !i_req_write[grant]};
            tag_id[0] <= grant;
            for (int i = 1; i <= RL; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    // capture read data when its tag reaches the end of the pipeline; data holds otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= tag_v[RL] ? {{(REQUESTERS-1){1'b0}}, 1'b1} << tag_id[RL] : '0;
            if (tag_v[RL]) o_rsp_data <= i_q;
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_memory_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N*DW-1:0] req_data = '0, req_mask = '0;
    logic [N-1:0]    ready1, ready3, rsp_valid1, rsp_valid3;
    logic [DW-1:0]   rsp_data1, rsp_data3, d1, d3, wem1, wem3;
    logic            me1, we1, me3, we3;
    logic [AW-1:0]   adr1, adr3;
    bit   [DW-1:0]   q1, q3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    memory_port_arbiter #(.REQUESTERS(N), .DATAW(DW), .WORDW(1024), .READ_LATENCY(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready1),
        .i_req_write(req_write), .i_req_address(req_address), .i_req_data(req_data),
        .i_req_mask(req_mask), .o_rsp_valid(rsp_valid1), .o_rsp_data(rsp_data1),
        .o_me(me1), .o_we(we1), .o_adr(adr1), .o_d(d1), .o_wem(wem1), .i_q(q1));

    memory_port_arbiter #(.REQUESTERS(N), .DATAW(DW), .WORDW(1024), .READ_LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready3),
        .i_req_write(req_write), .i_req_address(req_address), .i_req_data(req_data),
        .i_req_mask(req_mask), .o_rsp_valid(rsp_valid3), .o_rsp_data(rsp_data3),
        .o_me(me3), .o_we(we3), .o_adr(adr3), .o_d(d3), .o_wem(wem3), .i_q(q3));

    // memories attached to each port, zero-initialised, read latency 1 and 3
    bit [DW-1:0] mem1 [1024];
    bit [DW-1:0] mem3 [1024];
    bit [DW-1:0] qp3 [3];
    assign q3 = qp3[2];

    always @(posedge clk) begin
        if (me1 && we1) mem1[adr1] <= (mem1[adr1] & ~wem1) | (d1 & wem1);
        if (me1 && !we1) q1 <= mem1[adr1];
        if (me3 && we3) mem3[adr3] <= (mem3[adr3] & ~wem3) | (d3 & wem3);
        if (me3 && !we3) qp3[0] <= mem3[adr3];
        qp3[1] <= qp3[0];
        qp3[2] <= qp3[1];
    end

    // reference model: pointer search, ordered response queues with due cycles
    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp1[$];
    rsp_t exp3[$];
    bit [DW-1:0] mmem [1024];
    int m_last = N - 1;
    int g;
    rsp_t r;
    logic e_me = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_adr = '0;
    logic [DW-1:0] e_d = '0, e_wem = '0, e_rd1 = '0, e_rd3 = '0;

    function automatic int rr(logic [N-1:0] v, int last);
        for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = N - 1;
            e_me = 1'b0; e_we = 1'b0; e_adr = '0; e_d = '0; e_wem = '0;
            e_rd1 = '0; e_rd3 = '0;
            exp1.delete();
            exp3.delete();
        end else begin
            if (exp1.size() > 0 && exp1[0].due == cyc) begin e_rd1 = exp1[0].data; void'(exp1.pop_front()); end
            if (exp3.size() > 0 && exp3[0].due == cyc) begin e_rd3 = exp3[0].data; void'(exp3.pop_front()); end
            g = rr(req_valid, m_last);
            if (g >= 0) begin
                m_last = g;
                e_me = 1'b1;
                e_we = req_write[g];
                e_adr = req_address[g*AW +: AW];
                e_d = req_data[g*DW +: DW];
                e_wem = req_mask[g*DW +: DW];
                if (req_write[g]) mmem[e_adr] = (mmem[e_adr] & ~e_wem) | (e_d & e_wem);
                else begin
                    r.id = g; r.data = mmem[e_adr];
                    r.due = cyc + 3; exp1.push_back(r);
                    r.due = cyc + 5; exp3.push_back(r);
                end
            end else begin
                e_me = 1'b0;
                e_we = 1'b0;
            end
            cyc++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic set_req(int k, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_address[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
        req_mask[k*DW +: DW] = m;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready1, me1, we1, adr1, d1, wem1, rsp_valid1, rsp_data1} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got ready=%b me=%b we=%b adr=%h d=%h wem=%h rv=%b rd=%h want all zero",
                ready1, me1, we1, adr1, d1, wem1, rsp_valid1, rsp_data1);
        end
        repeat (2) tick();
        @(negedge clk);
        n_cmp++;
        if ({ready1, ready3, me3, rsp_valid3} !== '0) begin
            n_err++; $display("FAIL reset_ready_held: got ready1=%b ready3=%b me3=%b rv3=%b want 0", ready1, ready3, me3, rsp_valid3);
        end
        tick();
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_preload;
        set_req(0, 1'b1, 10'h010, 32'hDEADBEEF, '1);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0001) begin n_err++; $display("FAIL first_grant: got %b want 0001", ready1); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({me1, we1, adr1, d1} !== {1'b1, 1'b1, 10'h010, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL preload_port: got me=%b we=%b adr=%h d=%h want 1 1 010 deadbeef", me1, we1, adr1, d1);
        end
        idle(3);
    endtask

    task automatic test_single_read;
        do_reset();
        set_req(2, 1'b0, 10'h010, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0100) begin n_err++; $display("FAIL s1_ready: got %b want 0100", ready1); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({me1, we1, adr1, rsp_valid1} !== {1'b1, 1'b0, 10'h010, 4'b0000}) begin
            n_err++; $display("FAIL s1_port: got me=%b we=%b adr=%h rv=%b want 1 0 010 0000", me1, we1, adr1, rsp_valid1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({me1, we1, adr1, rsp_valid1} !== {1'b0, 1'b0, 10'h010, 4'b0000}) begin
            n_err++; $display("FAIL s1_idle_hold: got me=%b we=%b adr=%h rv=%b want 0 0 010 0000", me1, we1, adr1, rsp_valid1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid1, rsp_data1} !== {4'b0100, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL s1_rsp: got rv=%b rd=%h want 0100 deadbeef", rsp_valid1, rsp_data1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid1, rsp_data1, rsp_valid3} !== {4'b0000, 32'hDEADBEEF, 4'b0000}) begin
            n_err++; $display("FAIL s1_rsp_hold: got rv=%b rd=%h rv3=%b want 0000 deadbeef 0000", rsp_valid1, rsp_data1, rsp_valid3);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid3, rsp_data3} !== {4'b0100, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL s1_rsp_lat3: got rv=%b rd=%h want 0100 deadbeef", rsp_valid3, rsp_data3);
        end
        idle(2);
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ready1 !== (4'b0001 << (i % 4)) || (i > 0 && me1 !== 1'b1)) begin
                n_err++; $display("FAIL s2_cycle%0d: got ready=%b me=%b want %b me=%b", i, ready1, me1, 4'b0001 << (i % 4), i > 0);
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (me1 !== 1'b1) begin n_err++; $display("FAIL s2_last_me: got %b want 1", me1); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (me1 !== 1'b0) begin n_err++; $display("FAIL s2_me_drop: got %b want 0", me1); end
        idle(8);
    endtask

    task automatic test_write_mask;
        set_req(1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 32'h0000FFFF);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0010) begin n_err++; $display("FAIL s3_wr_ready: got %b want 0010", ready1); end
        tick();
        req_valid = '0;
        set_req(3, 1'b0, 10'h3FF, '0, '0);
        @(negedge clk);
        n_cmp++;
        if ({me1, we1, adr1, d1, wem1, ready1} !== {1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 32'h0000FFFF, 4'b1000}) begin
            n_err++; $display("FAIL s3_wr_port: got me=%b we=%b adr=%h d=%h wem=%h ready=%b want 1 1 3ff ffffffff 0000ffff 1000",
                me1, we1, adr1, d1, wem1, ready1);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({me1, we1, rsp_valid1} !== {1'b1, 1'b0, 4'b0000}) begin
            n_err++; $display("FAIL s3_rd_port: got me=%b we=%b rv=%b want 1 0 0000", me1, we1, rsp_valid1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid1 !== 4'b0000) begin n_err++; $display("FAIL s3_no_wr_rsp: got %b want 0000", rsp_valid1); end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid1, rsp_data1} !== {4'b1000, 32'h0000FFFF}) begin
            n_err++; $display("FAIL s3_rd_rsp: got rv=%b rd=%h want 1000 0000ffff", rsp_valid1, rsp_data1);
        end
        idle(8);
    endtask

    task automatic test_back_to_back;
        set_req(0, 1'b0, 10'h010, '0, '0);
        set_req(2, 1'b0, 10'h3FF, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready3 !== 4'b0001) begin n_err++; $display("FAIL s4_ready_t0: got %b want 0001", ready3); end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ready3 !== 4'b0100) begin n_err++; $display("FAIL s4_ready_t1: got %b want 0100", ready3); end
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid1, rsp_data1} !== {4'b0001, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL s4_lat1_first: got rv=%b rd=%h want 0001 deadbeef", rsp_valid1, rsp_data1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid1, rsp_data1, rsp_valid3} !== {4'b0100, 32'h0000FFFF, 4'b0000}) begin
            n_err++; $display("FAIL s4_lat1_second: got rv=%b rd=%h rv3=%b want 0100 0000ffff 0000", rsp_valid1, rsp_data1, rsp_valid3);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid3, rsp_data3} !== {4'b0001, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL s4_lat3_first: got rv=%b rd=%h want 0001 deadbeef", rsp_valid3, rsp_data3);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid3, rsp_data3} !== {4'b0100, 32'h0000FFFF}) begin
            n_err++; $display("FAIL s4_lat3_second: got rv=%b rd=%h want 0100 0000ffff", rsp_valid3, rsp_data3);
        end
        idle(4);
    endtask

    task automatic test_wrap;
        set_req(1, 1'b0, 10'h001, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0010) begin n_err++; $display("FAIL s5_r1_ready: got %b want 0010", ready1); end
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 10'h002, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0001) begin n_err++; $display("FAIL s5_wrap: got %b want 0001", ready1); end
        tick();
        req_valid = '0;
        set_req(1, 1'b0, 10'h001, '0, '0);
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 10'h002, '0, '0);
        set_req(2, 1'b0, 10'h003, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0100) begin n_err++; $display("FAIL s5_skip_to_2: got %b want 0100", ready1); end
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b0001) begin n_err++; $display("FAIL s5_then_0: got %b want 0001", ready1); end
        idle(8);
    endtask

    task automatic test_reset_inflight;
        set_req(3, 1'b0, 10'h010, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (ready1 !== 4'b1000) begin n_err++; $display("FAIL s6_ready: got %b want 1000", ready1); end
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 10'h010, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({me1, me3, rsp_valid1, rsp_valid3, ready1, ready3} !== '0) begin
            n_err++; $display("FAIL s6_async: got me=%b me3=%b rv=%b rv3=%b ready=%b ready3=%b want 0",
                me1, me3, rsp_valid1, rsp_valid3, ready1, ready3);
        end
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid1, rsp_valid3} !== '0) begin
                n_err++; $display("FAIL s6_no_rsp_cycle%0d: got rv=%b rv3=%b want 0", i, rsp_valid1, rsp_valid3);
            end
            tick();
        end
    endtask

    task automatic test_random;
        logic [N-1:0] hs = '0;
        logic [N-1:0] xr, xv1, xv3;
        logic [DW-1:0] xd1, xd3;
        int gg;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || hs[k]) begin
                    req_valid[k] = (i < 390) && ($urandom_range(0, 9) < 6);
                    req_write[k] = ($urandom_range(0, 2) == 0);
                    req_address[k*AW +: AW] = AW'($urandom_range(0, 15));
                    req_data[k*DW +: DW] = $urandom;
                    req_mask[k*DW +: DW] = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom;
                end else if ($urandom_range(0, 7) == 0 || i >= 390) req_valid[k] = 1'b0;
            end
            @(negedge clk);
            gg = rr(req_valid, m_last);
            xr = (gg < 0) ? '0 : 4'b0001 << gg;
            xv1 = (exp1.size() > 0 && exp1[0].due == cyc) ? 4'b0001 << exp1[0].id : '0;
            xd1 = (exp1.size() > 0 && exp1[0].due == cyc) ? exp1[0].data : e_rd1;
            xv3 = (exp3.size() > 0 && exp3[0].due == cyc) ? 4'b0001 << exp3[0].id : '0;
            xd3 = (exp3.size() > 0 && exp3[0].due == cyc) ? exp3[0].data : e_rd3;
            n_cmp++;
            if ({ready1, ready3} !== {xr, xr}) begin
                n_err++; $display("FAIL rnd_ready@%0d: got %b/%b want %b", i, ready1, ready3, xr);
            end
            n_cmp++;
            if ({me1, we1, adr1, d1, wem1, me3} !== {e_me, e_we, e_adr, e_d, e_wem, e_me}) begin
                n_err++; $display("FAIL rnd_port@%0d: got me=%b we=%b adr=%h d=%h wem=%h me3=%b want %b %b %h %h %h",
                    i, me1, we1, adr1, d1, wem1, me3, e_me, e_we, e_adr, e_d, e_wem);
            end
            n_cmp++;
            if ({rsp_valid1, rsp_data1} !== {xv1, xd1}) begin
                n_err++; $display("FAIL rnd_rsp_lat1@%0d: got rv=%b rd=%h want %b %h", i, rsp_valid1, rsp_data1, xv1, xd1);
            end
            n_cmp++;
            if ({rsp_valid3, rsp_data3} !== {xv3, xd3}) begin
                n_err++; $display("FAIL rnd_rsp_lat3@%0d: got rv=%b rd=%h want %b %h", i, rsp_valid3, rsp_data3, xv3, xd3);
            end
            hs = ready1 & req_valid;
            tick();
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_single_read();
        test_round_robin();
        test_write_mask();
        test_back_to_back();
        test_wrap();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
